cw305_ecg_reg_bank: RTL



---
 rtl/cw305_ecg_reg_bank.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cw305_ecg_reg_bank.sv
// Byte-wide register bank between the USB register front end and the ECG core:
// sample FIFO feeding the core, run control FSM, and result/status readback.
module cw305_ecg_reg_bank #(
  parameter int           pADDR_WIDTH   = 21,
  parameter int           pBYTECNT_SIZE = 7,
  parameter int           pFIFO_DEPTH   = 64,
  parameter int           pRESULT_WIDTH = 32,
  parameter logic [7:0]   pID           = 8'hEC
) (
  input  logic                                 usb_clk,
  input  logic                                 rst_n,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  input  logic [7:0]                           reg_datao,
  output logic [7:0]                           reg_datai,
  input  logic                                 reg_read,
  input  logic                                 reg_write,
  input  logic                                 reg_addrvalid,
  output logic [15:0]                          smp_data,
  output logic                                 smp_valid,
  input  logic                                 smp_ready,
  output logic                                 core_start,
  input  logic                                 core_done,
  input  logic [pRESULT_WIDTH-1:0]             core_result
);

  localparam int AW = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int PW = $clog2(pFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RB = pRESULT_WIDTH / 8;

  localparam logic [AW-1:0] A_CTRL   = AW'(0);
  localparam logic [AW-1:0] A_STATUS = AW'(1);
  localparam logic [AW-1:0] A_SAMPLE = AW'(2);
  localparam logic [AW-1:0] A_COUNT  = AW'(3);
  localparam logic [AW-1:0] A_RESULT = AW'(4);
  localparam logic [AW-1:0] A_ID     = AW'(5);

  localparam logic [pBYTECNT_SIZE-1:0] B0 = '0;
  localparam logic [pBYTECNT_SIZE-1:0] B1 = pBYTECNT_SIZE'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                     r_state, w_state_nxt;
  logic                       r_wr_q;
  logic [7:0]                 r_low;
  logic [7:0]                 r_datai;
  logic                       r_core_start;
  logic [pRESULT_WIDTH-1:0]   r_result;
  logic [15:0]                r_mem [pFIFO_DEPTH];
  logic [PW-1:0]              r_wptr, r_rptr;
  logic [CW-1:0]              r_count;
  logic                       r_ovf;

  logic w_wr_edge, w_ctrl_wr, w_start, w_flush, w_clr;
  logic w_smp_wr, w_push_lo, w_push, w_do_push, w_pop;
  logic w_full, w_empty, w_busy, w_done, w_start_ok, w_latch;
  logic [15:0] w_cnt_ext;
  logic [7:0]  w_rdata;
  logic        w_unused;

  // Reads are decoded every cycle, so the read strobe carries no extra meaning.
  assign w_unused = reg_read;

  // Only the rising cycle of a write acts; the front end may hold reg_write.
  assign w_wr_edge = reg_write & reg_addrvalid & ~r_wr_q;
  assign w_ctrl_wr = w_wr_edge & (reg_address == A_CTRL) & (reg_bytecnt == B0);
  assign w_start   = w_ctrl_wr & reg_datao[0];
  assign w_flush   = w_ctrl_wr & reg_datao[1];
  assign w_clr     = w_ctrl_wr & reg_datao[2];
  assign w_smp_wr  = w_wr_edge & (reg_address == A_SAMPLE);
  assign w_push_lo = w_smp_wr & (reg_bytecnt == B0);
  assign w_push    = w_smp_wr & (reg_bytecnt == B1);

  assign w_full    = (r_count == CW'(pFIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = w_push & ~w_full;
  assign w_busy    = (r_state == S_RUN);
  assign w_done    = (r_state == S_DONE);
  assign smp_valid = w_busy & ~w_empty;
  assign smp_data  = r_mem[r_rptr];
  assign w_pop     = smp_valid & smp_ready;
  assign w_latch   = w_busy & core_done;

  always_ff @(posedge usb_clk) begin
    if (!rst_n) begin
      r_wr_q <= 1'b0;
      r_low  <= 8'h00;
    end else begin
      r_wr_q <= reg_write & reg_addrvalid;
      if (w_push_lo) r_low <= reg_datao;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (w_do_push) r_mem[r_wptr] <= {reg_datao, r_low};
  end

  // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
  always_ff @(posedge usb_clk) begin
    if (!rst_n || w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      if (w_push && w_full) r_ovf <= 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_empty) begin
          w_state_nxt = S_RUN;
          w_start_ok  = 1'b1;
        end
      end
      S_RUN: begin
        if (core_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_start && !w_empty) begin
          w_state_nxt = S_RUN;
          w_start_ok  = 1'b1;
        end else if (w_clr) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_core_start <= 1'b0;
      r_result     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_start <= w_start_ok;
      if (w_latch) r_result <= core_result;
    end
  end

  assign core_start = r_core_start;
  assign w_cnt_ext  = 16'(r_count);

  always_comb begin
    w_rdata = 8'h00;
    case (reg_address)
      A_STATUS: if (reg_bytecnt == B0)
                  w_rdata = {3'b000, r_ovf, w_empty, w_full, w_done, w_busy};
      A_COUNT:  if (reg_bytecnt == B0)
                  w_rdata = (w_cnt_ext > 16'd255) ? 8'hFF : w_cnt_ext[7:0];
      A_RESULT: begin
        for (int n = 0; n < RB; n++)
          if (reg_bytecnt == pBYTECNT_SIZE'(n)) w_rdata = r_result[8*n +: 8];
      end
      A_ID:     if (reg_bytecnt == B0) w_rdata = pID;
      default:  w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (!rst_n) r_datai <= 8'h00;
    else        r_datai <= w_rdata;
  end

  assign reg_datai = r_datai;

endmodule
